rv_multicycle_ctrl: RTL
=======================

# rv_multicycle_ctrl

Sequencing controller for the multi-cycle RV32I datapath. It steps each instruction through FETCH, DECODE, EXEC, MEM and WB. It handles the instruction- and data-memory handshakes and latches the decoded instruction class. It drives the immediate-generator select (`ImmType`), PC, register-file and ALU-operand controls. It sits between the instruction register and every datapath mux/enable, and replaces hard-wired single-cycle decode.

## Interface
Parameters:
- `RESET_TRAP_STICKY`, default 1: when 1, `illegal` stays high until reset; when 0 it clears on the next FETCH.

Ports:
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-low reset
- `instr`  in  32  instruction-register contents, valid from DECODE onward
- `imem_ready`  in  1  instruction memory has data this cycle
- `dmem_ready`  in  1  data access completes this cycle
- `br_taken`  in  1  ALU branch-compare result, valid in EXEC
- `imem_req`  out  1  fetch request
- `ir_we`  out  1  load instruction register
- `dmem_req`  out  1  data access request
- `dmem_we`  out  1  data access is a store
- `pc_we`  out  1  update PC
- `pc_sel`  out  2  next-PC source: 0 = PC+4, 1 = PC+imm, 2 = (rs1+imm)&~1
- `alu_a_sel`  out  1  0 = rs1, 1 = PC
- `alu_b_sel`  out  1  0 = rs2, 1 = imm
- `ImmType`  out  3  immediate-generator select: 0 none, 1 I, 2 S, 3 B, 4 U, 5 J
- `rf_we`  out  1  register-file write
- `wb_sel`  out  2  0 = ALU, 1 = load data, 2 = PC+4, 3 = imm (LUI)
- `illegal`  out  1  unsupported opcode trapped

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, TRAP.
- FETCH:
  - `imem_req`=1 held until `imem_ready`.
  - On `imem_ready`: `ir_we`=1 the same cycle, then go to DECODE.
- DECODE: single cycle. Classify `instr[6:0]` and register the class and `ImmType`:
  - 0110011 OP → type 0
  - 0010011 OP-IMM → type 1
  - 0000011 LOAD → type 1
  - 1100111 JALR → type 1
  - 0100011 STORE → type 2
  - 1100011 BRANCH → type 3
  - 0110111 LUI → type 4
  - 0010111 AUIPC → type 4
  - 1101111 JAL → type 5
  - Any other opcode → TRAP, type 0.
- EXEC: single cycle.
  - `alu_a_sel`=1 for AUIPC; `alu_b_sel`=1 for every class except OP and BRANCH.
  - BRANCH: `pc_we`=1; `pc_sel`=1 if `br_taken`, else 0; next state FETCH.
  - LOAD/STORE → MEM. All other classes → WB.
- MEM:
  - `dmem_req`=1 held until `dmem_ready`; `dmem_we`=1 for STORE.
  - LOAD → WB on ready.
  - STORE: `pc_we`=1, `pc_sel`=0 on the ready cycle, then FETCH.
- WB: single cycle; `rf_we`=1, `pc_we`=1, then FETCH.
  - `wb_sel`: OP/OP-IMM/AUIPC 0; LOAD 1; JAL/JALR 2; LUI 3.
  - `pc_sel`: JAL 1, JALR 2, otherwise 0.
- TRAP: all strobes 0, `illegal`=1, no exit except reset (`RESET_TRAP_STICKY`=1).
- `ImmType`, `alu_*_sel`, `wb_sel` are registered and stable from EXEC through WB. They are 0 in FETCH.

## Timing
- Reset (`rst`=0 at any edge, including mid-handshake):
  - Next state is FETCH.
  - Every output is 0 at that edge, including `ImmType` and `illegal`.
  - An outstanding `imem_req`/`dmem_req` is dropped. A `dmem_ready` arriving after reset is ignored.
- `ir_we`, `pc_we`, `rf_we` are single-cycle pulses per instruction; there are never two `pc_we` pulses per instruction.
- Zero-wait memory (ready in the first request cycle): BRANCH 3 cycles, STORE 4, OP/OP-IMM/LUI/AUIPC/JAL/JALR 4, LOAD 5.
- Each wait cycle on either memory adds exactly one cycle. Request is held high throughout, and all other outputs hold.
- `imem_ready`/`dmem_ready` are ignored while the matching request is low.
- `br_taken` is sampled only in EXEC.

## Structure
- Shared package `rv_ctrl_pkg`:
  - state enum
  - opcode constants
  - `ImmType` encodings (IMM_NONE..IMM_J = 0..5)
  - `pc_sel` and `wb_sel` encodings
  - The existing immediate generator imports the same `ImmType` constants.
- One sub-module, `rv_opcode_decode`: purely combinational opcode → {class, ImmType, illegal}. It is instantiated once and its outputs are latched by the FSM in DECODE.

## Test plan
- ADDI x1,x0,5 (0x00500093), zero-wait: `ImmType`=1 in EXEC; `rf_we` pulses in cycle 4 with `wb_sel`=0; `pc_we` with `pc_sel`=0.
- BEQ (0x00208463), `br_taken`=1 then `br_taken`=0: `ImmType`=3; cycle-3 `pc_we` with `pc_sel`=1 / 0; `rf_we` never asserted.
- LW (0x0000A103) with `dmem_ready` delayed 2 cycles: `dmem_req` high 3 cycles, `dmem_we`=0; `rf_we` with `wb_sel`=1 at cycle 7.
- SW (0x0020A023) then JAL (0x008000EF): store `dmem_we`=1, `ImmType`=2; JAL `ImmType`=5, `wb_sel`=2, `pc_sel`=1.
- Opcode 0x0000007F: `illegal`=1 from the cycle after DECODE, all strobes 0 indefinitely; `rst`=0 clears it and restarts in FETCH.
- `rst`=0 during a MEM wait: next cycle `dmem_req`=0, state FETCH, `imem_req`=1 after `rst` returns high.

Source files
------------

// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I sequencing controller and the
// immediate generator: FSM states, opcodes, instruction classes and mux selects.
package rv_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_TRAP
  } state_t;

  typedef enum logic [3:0] {
    CLS_OP,
    CLS_OPIMM,
    CLS_LOAD,
    CLS_STORE,
    CLS_BRANCH,
    CLS_LUI,
    CLS_AUIPC,
    CLS_JAL,
    CLS_JALR
  } cls_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic [2:0] IMM_NONE = 3'd0;
  localparam logic [2:0] IMM_I    = 3'd1;
  localparam logic [2:0] IMM_S    = 3'd2;
  localparam logic [2:0] IMM_B    = 3'd3;
  localparam logic [2:0] IMM_U    = 3'd4;
  localparam logic [2:0] IMM_J    = 3'd5;

  localparam logic [1:0] PC_PLUS4 = 2'd0;
  localparam logic [1:0] PC_REL   = 2'd1;
  localparam logic [1:0] PC_JALR  = 2'd2;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;
  localparam logic [1:0] WB_IMM = 2'd3;

  function automatic logic [1:0] wb_sel_of(input cls_t c);
    case (c)
      CLS_LOAD:          return WB_MEM;
      CLS_JAL, CLS_JALR: return WB_PC4;
      CLS_LUI:           return WB_IMM;
      default:           return WB_ALU;
    endcase
  endfunction

endpackage

// File: rtl/rv_opcode_decode.sv
// Combinational opcode classifier: maps instr[6:0] to instruction class,
// immediate format and an illegal flag for unsupported opcodes.
module rv_opcode_decode
  import rv_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  output cls_t       cls,
  output logic [2:0] imm_type,
  output logic       illegal
);

  always_comb begin
    cls      = CLS_OP;
    imm_type = IMM_NONE;
    illegal  = 1'b0;
    case (opcode)
      OPC_OP:     cls = CLS_OP;
      OPC_OPIMM:  begin cls = CLS_OPIMM;  imm_type = IMM_I; end
      OPC_LOAD:   begin cls = CLS_LOAD;   imm_type = IMM_I; end
      OPC_JALR:   begin cls = CLS_JALR;   imm_type = IMM_I; end
      OPC_STORE:  begin cls = CLS_STORE;  imm_type = IMM_S; end
      OPC_BRANCH: begin cls = CLS_BRANCH; imm_type = IMM_B; end
      OPC_LUI:    begin cls = CLS_LUI;    imm_type = IMM_U; end
      OPC_AUIPC:  begin cls = CLS_AUIPC;  imm_type = IMM_U; end
      OPC_JAL:    begin cls = CLS_JAL;    imm_type = IMM_J; end
      default:    illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/rv_multicycle_ctrl.sv
// Multi-cycle RV32I sequencer: FETCH/DECODE/EXEC/MEM/WB with memory handshakes,
// decoded controls latched in DECODE and held through WB.
module rv_multicycle_ctrl
  import rv_ctrl_pkg::*;
#(
  parameter bit RESET_TRAP_STICKY = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  input  logic        br_taken,
  output logic        imem_req,
  output logic        ir_we,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic        alu_a_sel,
  output logic        alu_b_sel,
  output logic [2:0]  ImmType,
  output logic        rf_we,
  output logic [1:0]  wb_sel,
  output logic        illegal
);

  state_t     state_q, state_d;
  cls_t       dec_cls;
  logic [2:0] dec_imm;
  logic       dec_ill;

  cls_t       cls_p1;
  logic [2:0] imm_p1;
  logic       a_sel_p1;
  logic       b_sel_p1;
  logic [1:0] wb_sel_p1;
  logic       illegal_q;

  // Only the opcode field steers sequencing; the rest belongs to the datapath.
  logic unused_instr_bits;
  assign unused_instr_bits = ^instr[31:7];

  rv_opcode_decode u_dec (
    .opcode  (instr[6:0]),
    .cls     (dec_cls),
    .imm_type(dec_imm),
    .illegal (dec_ill)
  );

  always_ff @(posedge clk) begin
    if (!rst) state_q <= ST_FETCH;
    else      state_q <= state_d;
  end

  // DECODE -> EXEC boundary: latch class and datapath selects, clear on return to FETCH
  always_ff @(posedge clk) begin
    if (!rst) begin
      cls_p1    <= CLS_OP;
      imm_p1    <= IMM_NONE;
      a_sel_p1  <= 1'b0;
      b_sel_p1  <= 1'b0;
      wb_sel_p1 <= WB_ALU;
      illegal_q <= 1'b0;
    end else if (state_q == ST_DECODE) begin
      cls_p1    <= dec_cls;
      imm_p1    <= dec_imm;
      a_sel_p1  <= (dec_cls == CLS_AUIPC);
      b_sel_p1  <= !((dec_cls == CLS_OP) || (dec_cls == CLS_BRANCH));
      wb_sel_p1 <= wb_sel_of(dec_cls);
      illegal_q <= dec_ill;
    end else if (state_d == ST_FETCH) begin
      imm_p1    <= IMM_NONE;
      a_sel_p1  <= 1'b0;
      b_sel_p1  <= 1'b0;
      wb_sel_p1 <= WB_ALU;
      if (!RESET_TRAP_STICKY) illegal_q <= 1'b0;
    end
  end

  always_comb begin
    state_d   = state_q;
    imem_req  = 1'b0;
    ir_we     = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    pc_we     = 1'b0;
    pc_sel    = PC_PLUS4;
    rf_we     = 1'b0;
    alu_a_sel = a_sel_p1;
    alu_b_sel = b_sel_p1;
    ImmType   = imm_p1;
    wb_sel    = wb_sel_p1;
    illegal   = illegal_q;
    case (state_q)
      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_we   = 1'b1;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: state_d = dec_ill ? ST_TRAP : ST_EXEC;
      ST_EXEC: begin
        case (cls_p1)
          CLS_BRANCH: begin
            pc_we   = 1'b1;
            pc_sel  = br_taken ? PC_REL : PC_PLUS4;
            state_d = ST_FETCH;
          end
          CLS_LOAD, CLS_STORE: state_d = ST_MEM;
          default:             state_d = ST_WB;
        endcase
      end
      ST_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (cls_p1 == CLS_STORE);
        if (dmem_ready) begin
          if (cls_p1 == CLS_STORE) begin
            pc_we   = 1'b1;
            state_d = ST_FETCH;
          end else begin
            state_d = ST_WB;
          end
        end
      end
      ST_WB: begin
        rf_we   = 1'b1;
        pc_we   = 1'b1;
        pc_sel  = (cls_p1 == CLS_JAL)  ? PC_REL  :
                  (cls_p1 == CLS_JALR) ? PC_JALR : PC_PLUS4;
        state_d = ST_FETCH;
      end
      ST_TRAP: if (!RESET_TRAP_STICKY) state_d = ST_FETCH;
      default: state_d = ST_FETCH;
    endcase
    // Reset holds every output low, including any outstanding memory request.
    if (!rst) begin
      imem_req  = 1'b0;
      ir_we     = 1'b0;
      dmem_req  = 1'b0;
      dmem_we   = 1'b0;
      pc_we     = 1'b0;
      pc_sel    = PC_PLUS4;
      rf_we     = 1'b0;
      alu_a_sel = 1'b0;
      alu_b_sel = 1'b0;
      ImmType   = IMM_NONE;
      wb_sel    = WB_ALU;
      illegal   = 1'b0;
    end
  end

endmodule
